// File: rtl/game_pkg.sv
// Shared types for the SkyHop game sequencer: FSM states, layer-enable bundle and hold defaults.
package game_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        READY = 2'd1,
        JUMP  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned DEF_HOLD_CYCLES = 65_000_000;
    localparam int unsigned HOLD_W          = $clog2(DEF_HOLD_CYCLES);

    typedef struct packed {
        logic start_screen;
        logic blocks;
        logic time_bar;
        logic character;
        logic points;
        logic end_screen;
        logic bg_over;
    } layers_t;

    // Screen layers visible while the sequencer sits in a given state.
    function automatic layers_t layers_for(input state_t s);
        layers_t l;
        l = '0;
        case (s)
            START: l.start_screen = 1'b1;
            READY, JUMP: begin
                l.blocks    = 1'b1;
                l.time_bar  = 1'b1;
                l.character = 1'b1;
                l.points    = 1'b1;
            end
            OVER: begin
                l.end_screen = 1'b1;
                l.points     = 1'b1;
                l.bg_over    = 1'b1;
            end
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/game_controller_hold_timer.sv
// Loadable down-counter that stops at zero; flags when the end-screen hold has expired.
module hold_timer
    import game_pkg::*;
#(
    parameter int unsigned W = HOLD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/game_controller.sv
// SkyHop game sequencer: start/ready/jump/over flow, layer enables, jump/timer pulses and score.
// Optional GAME_CTRL_BEST_SCORE_EN adds a best_score output kept across games until reset.
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned SCORE_W     = 10,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_start,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               jump_fail,
    input  logic               time_elapsed,
    input  logic               character_landed,
    output logic               start_screen_en,
    output logic               blocks_en,
    output logic               time_bar_en,
    output logic               character_en,
    output logic               points_en,
    output logic               end_screen_en,
    output logic               bg_clor_select,
    output logic               jump_left,
    output logic               jump_right,
    output logic               timer_start,
`ifdef GAME_CTRL_BEST_SCORE_EN
    output logic [SCORE_W-1:0] best_score,
`endif
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned        CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             r_state;
    layers_t            r_layers;
    logic               r_jump_left;
    logic               r_jump_right;
    logic               r_timer_start;
    logic [SCORE_W-1:0] r_score;

    state_t w_next;
    logic   w_jump_left;
    logic   w_jump_right;
    logic   w_timer_start;
    logic   w_score_clr;
    logic   w_score_inc;
    logic   w_enter_over;
    logic   w_hold_zero;

    hold_timer #(.W(CNT_W)) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_enter_over),
        .i_load_val (HOLD_LOAD),
        .o_zero_c   (w_hold_zero)
    );

    // Next-state and pulse decode; jump_fail outranks time_elapsed outranks landing.
    always_comb begin
        w_next        = r_state;
        w_jump_left   = 1'b0;
        w_jump_right  = 1'b0;
        w_timer_start = 1'b0;
        w_score_clr   = 1'b0;
        w_score_inc   = 1'b0;
        case (r_state)
            START: begin
                if (key_start) begin
                    w_next        = READY;
                    w_timer_start = 1'b1;
                    w_score_clr   = 1'b1;
                end
            end
            READY: begin
                if (time_elapsed) begin
                    w_next = OVER;
                end else if (key_left ^ key_right) begin
                    w_next       = JUMP;
                    w_jump_left  = key_left;
                    w_jump_right = key_right;
                end
            end
            JUMP: begin
                if (jump_fail || time_elapsed) begin
                    w_next = OVER;
                end else if (character_landed) begin
                    w_next        = READY;
                    w_timer_start = 1'b1;
                    w_score_inc   = 1'b1;
                end
            end
            OVER: begin
                if (key_start && w_hold_zero) begin
                    w_next = START;
                end
            end
            default: w_next = START;
        endcase
    end

    assign w_enter_over = (w_next == OVER) && (r_state != OVER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= START;
            r_layers      <= layers_for(START);
            r_jump_left   <= 1'b0;
            r_jump_right  <= 1'b0;
            r_timer_start <= 1'b0;
            r_score       <= '0;
        end else begin
            r_state       <= w_next;
            r_layers      <= layers_for(w_next);
            r_jump_left   <= w_jump_left;
            r_jump_right  <= w_jump_right;
            r_timer_start <= w_timer_start;
            if (w_score_clr) begin
                r_score <= '0;
            end else if (w_score_inc && (r_score != SCORE_MAX)) begin
                r_score <= r_score + SCORE_W'(1);
            end
        end
    end

`ifdef GAME_CTRL_BEST_SCORE_EN
    logic [SCORE_W-1:0] r_best_score;

    // Score cannot change on the cycle OVER is entered, so r_score is the final game score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_best_score <= '0;
        end else if (w_enter_over && (r_score > r_best_score)) begin
            r_best_score <= r_score;
        end
    end

    assign best_score = r_best_score;
`endif

    assign start_screen_en = r_layers.start_screen;
    assign blocks_en       = r_layers.blocks;
    assign time_bar_en     = r_layers.time_bar;
    assign character_en    = r_layers.character;
    assign points_en       = r_layers.points;
    assign end_screen_en   = r_layers.end_screen;
    assign bg_clor_select  = r_layers.bg_over;
    assign jump_left       = r_jump_left;
    assign jump_right      = r_jump_right;
    assign timer_start     = r_timer_start;
    assign score           = r_score;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller (SCORE_W=4, HOLD_CYCLES=8); honours GAME_CTRL_BEST_SCORE_EN.
module tb_game_controller;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned HOLD    = 8;
    localparam logic [6:0]  L_START = 7'b1000000;
    localparam logic [6:0]  L_PLAY  = 7'b0111100;
    localparam logic [6:0]  L_OVER  = 7'b0000111;

    logic clk, rst;
    logic key_start, key_left, key_right, jump_fail, time_elapsed, character_landed;
    logic start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en, bg_clor_select;
    logic jump_left, jump_right, timer_start;
    logic [SCORE_W-1:0] score;
`ifdef GAME_CTRL_BEST_SCORE_EN
    logic [SCORE_W-1:0] best_score;
`endif
    logic [6:0] layers;

    int errors = 0;
    int checks = 0;

    game_controller #(.SCORE_W(SCORE_W), .HOLD_CYCLES(HOLD)) dut (
        .clk              (clk),
        .rst              (rst),
        .key_start        (key_start),
        .key_left         (key_left),
        .key_right        (key_right),
        .jump_fail        (jump_fail),
        .time_elapsed     (time_elapsed),
        .character_landed (character_landed),
        .start_screen_en  (start_screen_en),
        .blocks_en        (blocks_en),
        .time_bar_en      (time_bar_en),
        .character_en     (character_en),
        .points_en        (points_en),
        .end_screen_en    (end_screen_en),
        .bg_clor_select   (bg_clor_select),
        .jump_left        (jump_left),
        .jump_right       (jump_right),
        .timer_start      (timer_start),
`ifdef GAME_CTRL_BEST_SCORE_EN
        .best_score       (best_score),
`endif
        .score            (score)
    );

    assign layers = {start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en, bg_clor_select};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs from a negedge; returns at the next negedge with inputs cleared.
    task automatic drive(input logic ks, input logic kl, input logic kr,
                         input logic jf, input logic te, input logic cl);
        key_start = ks; key_left = kl; key_right = kr;
        jump_fail = jf; time_elapsed = te; character_landed = cl;
        @(negedge clk);
        key_start = 1'b0; key_left = 1'b0; key_right = 1'b0;
        jump_fail = 1'b0; time_elapsed = 1'b0; character_landed = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (layers !== L_START) begin errors++; $display("FAIL reset_layers: got %b want %b", layers, L_START); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if ({jump_left, jump_right, timer_start} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {jump_left, jump_right, timer_start}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({layers, timer_start} !== {L_START, 1'b0}) begin errors++; $display("FAIL release_idle: got %b want %b", {layers, timer_start}, {L_START, 1'b0}); end
    endtask

    task automatic test_start;
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({layers, jump_left} !== {L_START, 1'b0}) begin errors++; $display("FAIL start_ignores_left: got %b want %b", {layers, jump_left}, {L_START, 1'b0}); end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (layers !== L_PLAY) begin errors++; $display("FAIL start_layers: got %b want %b", layers, L_PLAY); end
        checks++; if (timer_start !== 1'b1) begin errors++; $display("FAIL start_timer_pulse: got %b want 1", timer_start); end
        checks++; if (score !== 4'd0) begin errors++; $display("FAIL start_score: got %0d want 0", score); end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (timer_start !== 1'b0) begin errors++; $display("FAIL start_timer_single: got %b want 0", timer_start); end
    endtask

    task automatic test_jumps;
        int exp;
        for (int i = 0; i < 20; i++) begin
            exp = (i + 1 > 15) ? 15 : i + 1;
            drive(0, 0, 1, 0, 0, 0);
            checks++; if ({jump_right, jump_left} !== 2'b10) begin errors++; $display("FAIL jump_right_pulse[%0d]: got %b want 10", i, {jump_right, jump_left}); end
            drive(0, 0, 0, 0, 0, 1);
            checks++; if ({jump_right, timer_start} !== 2'b01) begin errors++; $display("FAIL land_pulses[%0d]: got %b want 01", i, {jump_right, timer_start}); end
            checks++; if (score !== SCORE_W'(exp)) begin errors++; $display("FAIL land_score[%0d]: got %0d want %0d", i, score, exp); end
        end
    endtask

    task automatic test_back_to_back_keys;
        drive(0, 1, 1, 0, 0, 0);
        checks++; if ({jump_left, jump_right} !== 2'b00) begin errors++; $display("FAIL both_keys_pulse: got %b want 00", {jump_left, jump_right}); end
        checks++; if (layers !== L_PLAY) begin errors++; $display("FAIL both_keys_layers: got %b want %b", layers, L_PLAY); end
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({jump_left, jump_right} !== 2'b10) begin errors++; $display("FAIL left_after_both: got %b want 10", {jump_left, jump_right}); end
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (jump_left !== 1'b0) begin errors++; $display("FAIL left_in_jump: got %b want 0", jump_left); end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (timer_start !== 1'b1) begin errors++; $display("FAIL land_after_ignored_left: got %b want 1", timer_start); end
        checks++; if (score !== 4'd15) begin errors++; $display("FAIL score_saturated: got %0d want 15", score); end
    endtask

    task automatic test_jump_fail;
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1);
        checks++; if (layers !== L_OVER) begin errors++; $display("FAIL fail_layers: got %b want %b", layers, L_OVER); end
        checks++; if ({timer_start, score} !== {1'b0, 4'd15}) begin errors++; $display("FAIL fail_score: got ts=%b score=%0d want ts=0 score=15", timer_start, score); end
`ifdef GAME_CTRL_BEST_SCORE_EN
        checks++; if (best_score !== 4'd15) begin errors++; $display("FAIL fail_best: got %0d want 15", best_score); end
`endif
    endtask

    task automatic test_hold;
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (layers !== L_OVER) begin errors++; $display("FAIL hold_early_key: got %b want %b", layers, L_OVER); end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (layers !== L_OVER) begin errors++; $display("FAIL hold_last_count: got %b want %b", layers, L_OVER); end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (layers !== L_START) begin errors++; $display("FAIL hold_expired: got %b want %b", layers, L_START); end
        checks++; if ({timer_start, score} !== {1'b0, 4'd15}) begin errors++; $display("FAIL hold_score_kept: got ts=%b score=%0d want ts=0 score=15", timer_start, score); end
    endtask

    task automatic test_async_reset;
        drive(1, 0, 0, 0, 0, 0);
        checks++; if ({layers, score} !== {L_PLAY, 4'd0}) begin errors++; $display("FAIL restart: got %b/%0d want %b/0", layers, score, L_PLAY); end
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({jump_left, score} !== {1'b1, 4'd1}) begin errors++; $display("FAIL pre_reset_jump: got jl=%b score=%0d want jl=1 score=1", jump_left, score); end
        #2 rst = 1'b0;
        #1;
        checks++; if (layers !== L_START) begin errors++; $display("FAIL async_layers: got %b want %b", layers, L_START); end
        checks++; if ({jump_left, jump_right, timer_start, score} !== 7'd0) begin errors++; $display("FAIL async_outputs: got %b want 0", {jump_left, jump_right, timer_start, score}); end
`ifdef GAME_CTRL_BEST_SCORE_EN
        checks++; if (best_score !== 4'd0) begin errors++; $display("FAIL async_best: got %0d want 0", best_score); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({layers, jump_left, jump_right, timer_start} !== {L_START, 3'b000}) begin errors++; $display("FAIL release_no_pulse: got %b want %b", {layers, jump_left, jump_right, timer_start}, {L_START, 3'b000}); end
    endtask

    task automatic test_best_score;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1);
        end
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        checks++; if ({layers, score} !== {L_OVER, 4'd5}) begin errors++; $display("FAIL game1_over: got %b/%0d want %b/5", layers, score, L_OVER); end
`ifdef GAME_CTRL_BEST_SCORE_EN
        checks++; if (best_score !== 4'd5) begin errors++; $display("FAIL game1_best: got %0d want 5", best_score); end
`endif
        repeat (7) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++; if ({layers, score} !== {L_PLAY, 4'd0}) begin errors++; $display("FAIL game2_start: got %b/%0d want %b/0", layers, score, L_PLAY); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1);
        end
        drive(0, 0, 1, 0, 1, 0);
        checks++; if ({layers, jump_right, score} !== {L_OVER, 1'b0, 4'd3}) begin errors++; $display("FAIL timeout_over: got %b/%b/%0d want %b/0/3", layers, jump_right, score, L_OVER); end
`ifdef GAME_CTRL_BEST_SCORE_EN
        checks++; if (best_score !== 4'd5) begin errors++; $display("FAIL game2_best: got %0d want 5", best_score); end
`endif
    endtask

    initial begin
        key_start = 1'b0; key_left = 1'b0; key_right = 1'b0;
        jump_fail = 1'b0; time_elapsed = 1'b0; character_landed = 1'b0;
        test_reset();
        test_start();
        test_jumps();
        test_back_to_back_keys();
        test_jump_fail();
        test_hold();
        test_async_reset();
        test_best_score();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
